// File: rtl/image_stream_pkg.sv
// Shared definitions for the frame streamer: geometry defaults, the
// address-width derivation and the streaming FSM state encoding.
package image_stream_pkg;

    localparam int DATA_SIZE = 8;
    localparam int ROW_SIZE  = 28;
    localparam int COL_SIZE  = 28;

    // Address width needed to index every pixel of a rows x cols frame.
    function automatic int addr_width(input int row_size, input int col_size);
        return $clog2(row_size * col_size);
    endfunction

    localparam int ADDR_WIDTH = addr_width(ROW_SIZE, COL_SIZE);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_e;

endpackage

// File: rtl/image_streamer_if.sv
// Host/sink bundle of the frame streamer: frame-RAM write port, stream
// control and the pixel/valid output toward image_buffer.
interface image_streamer_if
    import image_stream_pkg::*;
#(
    parameter int DATA_SIZE  = image_stream_pkg::DATA_SIZE,
    parameter int ADDR_WIDTH = image_stream_pkg::ADDR_WIDTH
) ();

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_SIZE-1:0]  wr_data;
    logic                  start;
    logic                  pause;
    logic [DATA_SIZE-1:0]  pixel_data_out;
    logic                  data_out_valid;
    logic                  row_last;
    logic                  frame_done;
    logic                  busy;

    // The streamer side: takes writes and control, drives the pixel stream.
    modport master (
        input  wr_en, wr_addr, wr_data, start, pause,
        output pixel_data_out, data_out_valid, row_last, frame_done, busy
    );

    // The host/sink side: loads the frame, controls streaming, consumes pixels.
    modport slave (
        output wr_en, wr_addr, wr_data, start, pause,
        input  pixel_data_out, data_out_valid, row_last, frame_done, busy
    );

endinterface

// File: rtl/image_streamer_frame_ram.sv
// Frame store: one write port, one synchronous read port. Storage is never
// reset so a loaded frame survives resets; only the read register clears.
module frame_ram #(
    parameter int DATA_SIZE  = 8,
    parameter int DEPTH      = 784,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_SIZE-1:0]  wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_SIZE-1:0]  rd_data
);

    logic [DATA_SIZE-1:0] mem_r [DEPTH];

    // Storage write; address range is qualified by the caller.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register doubles as the pixel output register; holds when idle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_data <= {DATA_SIZE{1'b0}};
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/image_streamer.sv
// Frame source for image_buffer: a host preloads one frame into the frame
// RAM, and a start pulse streams it out in raster order with pause bubbles,
// row-end and frame-end markers.
module image_streamer
    import image_stream_pkg::*;
#(
    parameter int DATA_SIZE  = image_stream_pkg::DATA_SIZE,
    parameter int ROW_SIZE   = image_stream_pkg::ROW_SIZE,
    parameter int COL_SIZE   = image_stream_pkg::COL_SIZE,
    parameter int ADDR_WIDTH = addr_width(ROW_SIZE, COL_SIZE)
) (
    input  logic             clock,
    input  logic             resetn,
    image_streamer_if.master bus
);

    localparam int DEPTH = ROW_SIZE * COL_SIZE;
    localparam int COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int ROW_W = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(ROW_SIZE - 1);

    stream_state_e         state_r;
    stream_state_e         state_next_s;
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic [COL_W-1:0]      col_r;
    logic [ROW_W-1:0]      row_r;
    logic                  rd_en_s;
    logic                  wr_ok_s;
    logic                  clear_s;
    logic                  last_s;
    logic                  valid_r;
    logic                  row_last_r;
    logic                  frame_done_r;
    logic [DATA_SIZE-1:0]  pixel_s;

    // FSM state register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and per-edge strobes: writes only in IDLE, reads only
    // in STREAM on unpaused edges.
    always_comb begin
        state_next_s = state_r;
        rd_en_s      = 1'b0;
        wr_ok_s      = 1'b0;
        clear_s      = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE: begin
                wr_ok_s = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_EXT);
                if (bus.start) begin
                    state_next_s = STREAM;
                    clear_s      = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            STREAM: begin
                if (!bus.pause) begin
                    rd_en_s = 1'b1;
                    if (rd_addr_r == LAST_ADDR) begin
                        last_s       = 1'b1;
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = STREAM;
                    end
                end else begin
                    state_next_s = STREAM;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Raster position: read address plus column/row counters, advanced per read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_addr_r <= {ADDR_WIDTH{1'b0}};
            col_r     <= {COL_W{1'b0}};
            row_r     <= {ROW_W{1'b0}};
        end else if (clear_s || last_s) begin
            rd_addr_r <= {ADDR_WIDTH{1'b0}};
            col_r     <= {COL_W{1'b0}};
            row_r     <= {ROW_W{1'b0}};
        end else if (rd_en_s) begin
            rd_addr_r <= rd_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (col_r == LAST_COL) begin
                col_r <= {COL_W{1'b0}};
                row_r <= row_r + {{(ROW_W-1){1'b0}}, 1'b1};
            end else begin
                col_r <= col_r + {{(COL_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // One-cycle output flags, all qualified by the read on this edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_r      <= 1'b0;
            row_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            valid_r      <= rd_en_s;
            row_last_r   <= rd_en_s && (col_r == LAST_COL);
            frame_done_r <= last_s;
        end
    end

    frame_ram #(
        .DATA_SIZE  (DATA_SIZE),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_frame_ram (
        .clock   (clock),
        .resetn  (resetn),
        .wr_en   (wr_ok_s),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en_s),
        .rd_addr (rd_addr_r),
        .rd_data (pixel_s)
    );

    assign bus.pixel_data_out = pixel_s;
    assign bus.data_out_valid = valid_r;
    assign bus.row_last       = row_last_r;
    assign bus.frame_done     = frame_done_r;
    assign bus.busy           = (state_r == STREAM);

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer: loads a raster ramp (i mod 256) and
// checks full frames, pause bubbles, mid-stream start/write immunity,
// back-to-back restart, mid-frame reset and write+start on the same edge.
module tb_image_streamer;
    import image_stream_pkg::*;

    localparam int NPIX   = 784;
    localparam int BUDGET = 3000;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    image_streamer_if #(.DATA_SIZE(8), .ADDR_WIDTH(10)) bus ();

    image_streamer #(
        .DATA_SIZE  (8),
        .ROW_SIZE   (28),
        .COL_SIZE   (28),
        .ADDR_WIDTH (10)
    ) dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.wr_en = 1'b0; bus.wr_addr = 10'd0; bus.wr_data = 8'd0;
        bus.start = 1'b0; bus.pause = 1'b0;
        resetn = 1'b0;
        #22;
        checks++;
        if ({bus.pixel_data_out, bus.data_out_valid, bus.row_last, bus.frame_done, bus.busy} !== 12'd0) begin
            failures++;
            $display("FAIL reset_outputs got pix=%h v=%b rl=%b fd=%b busy=%b want all 0",
                     bus.pixel_data_out, bus.data_out_valid, bus.row_last, bus.frame_done, bus.busy);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
    endtask

    task automatic load_frame();
        for (int i = 0; i < NPIX; i++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 10'(i); bus.wr_data = 8'(i);
            tick();
        end
        // Out-of-range write must be dropped.
        bus.wr_addr = 10'd784; bus.wr_data = 8'h55;
        tick();
        bus.wr_en = 1'b0;
        tick();
    endtask

    task automatic test_stream();
        int idx = 0;
        int cyc = 0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.data_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_start got busy=%b v=%b want busy=1 v=0", bus.busy, bus.data_out_valid);
        end
        while (idx < NPIX && cyc < BUDGET) begin
            tick(); cyc++;
            checks++;
            if (bus.data_out_valid !== 1'b1) begin
                failures++;
                $display("FAIL stream_valid cycle %0d got v=%b want 1", cyc, bus.data_out_valid);
            end else begin
                checks++;
                if (bus.pixel_data_out !== 8'(idx) || bus.row_last !== (idx % 28 == 27) || bus.frame_done !== (idx == NPIX - 1)) begin
                    failures++;
                    $display("FAIL stream_pixel idx %0d got pix=%h rl=%b fd=%b want pix=%h rl=%b fd=%b", idx,
                             bus.pixel_data_out, bus.row_last, bus.frame_done, 8'(idx), (idx % 28 == 27), (idx == NPIX - 1));
                end
                idx++;
            end
        end
        checks++;
        if (idx != NPIX || cyc != NPIX || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL stream_end got idx=%0d cycles=%0d busy=%b want %0d %0d busy=0", idx, cyc, bus.busy, NPIX, NPIX);
        end
        tick();
        checks++;
        if (bus.data_out_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL stream_after got v=%b fd=%b want 0 0", bus.data_out_valid, bus.frame_done);
        end
    endtask

    task automatic test_pause();
        int idx = 0;
        int cyc = 0;
        logic p;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        while (idx < NPIX && cyc < BUDGET) begin
            p = (cyc % 3 == 2);
            bus.pause = p;
            tick(); cyc++;
            checks++;
            if (bus.data_out_valid !== !p) begin
                failures++;
                $display("FAIL pause_valid cycle %0d got v=%b want %b", cyc, bus.data_out_valid, !p);
            end
            if (bus.data_out_valid === 1'b1) begin
                checks++;
                if (bus.pixel_data_out !== 8'(idx) || bus.row_last !== (idx % 28 == 27) || bus.frame_done !== (idx == NPIX - 1)) begin
                    failures++;
                    $display("FAIL pause_pixel idx %0d got pix=%h rl=%b fd=%b want pix=%h", idx,
                             bus.pixel_data_out, bus.row_last, bus.frame_done, 8'(idx));
                end
                idx++;
            end else begin
                checks++;
                if (bus.row_last !== 1'b0 || bus.frame_done !== 1'b0 || (idx > 0 && bus.pixel_data_out !== 8'(idx - 1))) begin
                    failures++;
                    $display("FAIL pause_hold idx %0d got pix=%h rl=%b fd=%b want pix=%h rl=0 fd=0", idx,
                             bus.pixel_data_out, bus.row_last, bus.frame_done, 8'(idx - 1));
                end
            end
        end
        bus.pause = 1'b0;
        checks++;
        if (idx != NPIX || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL pause_end got idx=%0d busy=%b want %0d busy=0", idx, bus.busy, NPIX);
        end
        tick();
    endtask

    task automatic test_ignore_mid();
        int idx = 0;
        int cyc = 0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        while (idx < NPIX && cyc < BUDGET) begin
            if (idx == 50 && bus.data_out_valid === 1'b1) begin
                bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 10'd0; bus.wr_data = 8'hAA;
            end else begin
                bus.start = 1'b0; bus.wr_en = 1'b0;
            end
            tick(); cyc++;
            if (bus.data_out_valid === 1'b1) begin
                checks++;
                if (bus.pixel_data_out !== 8'(idx) || bus.frame_done !== (idx == NPIX - 1)) begin
                    failures++;
                    $display("FAIL ignore_pixel idx %0d got pix=%h fd=%b want pix=%h", idx,
                             bus.pixel_data_out, bus.frame_done, 8'(idx));
                end
                idx++;
            end
        end
        bus.start = 1'b0; bus.wr_en = 1'b0;
        checks++;
        if (idx != NPIX || cyc != NPIX) begin
            failures++;
            $display("FAIL ignore_len got idx=%0d cycles=%0d want %0d %0d", idx, cyc, NPIX, NPIX);
        end
    endtask

    // Called right after the last pixel of the previous frame.
    task automatic test_back_to_back();
        int idx = 0;
        int cyc = 0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        checks++;
        if (bus.data_out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap got v=%b busy=%b want v=0 busy=1", bus.data_out_valid, bus.busy);
        end
        tick();
        checks++;
        if (bus.data_out_valid !== 1'b1 || bus.pixel_data_out !== 8'h00) begin
            failures++;
            $display("FAIL b2b_first got v=%b pix=%h want v=1 pix=00", bus.data_out_valid, bus.pixel_data_out);
        end
        idx = 1;
        while (idx < NPIX && cyc < BUDGET) begin
            tick(); cyc++;
            if (bus.data_out_valid === 1'b1) begin
                checks++;
                if (bus.pixel_data_out !== 8'(idx)) begin
                    failures++;
                    $display("FAIL b2b_pixel idx %0d got %h want %h", idx, bus.pixel_data_out, 8'(idx));
                end
                idx++;
            end
        end
        checks++;
        if (idx != NPIX || bus.frame_done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_end got idx=%0d fd=%b want %0d fd=1", idx, bus.frame_done, NPIX);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int idx = 0;
        int cyc = 0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        while (idx <= 100 && cyc < BUDGET) begin
            tick(); cyc++;
            if (bus.data_out_valid === 1'b1) idx++;
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.pixel_data_out, bus.data_out_valid, bus.row_last, bus.frame_done, bus.busy} !== 12'd0) begin
            failures++;
            $display("FAIL reset_mid got pix=%h v=%b busy=%b want all 0 (idx=%0d)",
                     bus.pixel_data_out, bus.data_out_valid, bus.busy, idx);
        end
        @(negedge clk);
        resetn = 1'b1;
        tick();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        idx = 0; cyc = 0;
        while (idx < NPIX && cyc < BUDGET) begin
            tick(); cyc++;
            if (bus.data_out_valid === 1'b1) begin
                checks++;
                if (bus.pixel_data_out !== 8'(idx)) begin
                    failures++;
                    $display("FAIL reset_restart idx %0d got %h want %h", idx, bus.pixel_data_out, 8'(idx));
                end
                idx++;
            end
        end
        checks++;
        if (idx != NPIX || cyc != NPIX) begin
            failures++;
            $display("FAIL reset_restart_len got idx=%0d cycles=%0d want %0d %0d", idx, cyc, NPIX, NPIX);
        end
        tick();
    endtask

    task automatic test_write_start();
        int cyc = 0;
        bus.wr_en = 1'b1; bus.wr_addr = 10'd0; bus.wr_data = 8'hC3; bus.start = 1'b1;
        tick();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        tick();
        checks++;
        if (bus.data_out_valid !== 1'b1 || bus.pixel_data_out !== 8'hC3) begin
            failures++;
            $display("FAIL write_start got v=%b pix=%h want v=1 pix=c3", bus.data_out_valid, bus.pixel_data_out);
        end
        while (bus.busy === 1'b1 && cyc < BUDGET) begin
            tick(); cyc++;
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.frame_done !== 1'b1 || bus.pixel_data_out !== 8'h0F) begin
            failures++;
            $display("FAIL write_start_end got busy=%b fd=%b pix=%h want busy=0 fd=1 pix=0f",
                     bus.busy, bus.frame_done, bus.pixel_data_out);
        end
    endtask

    initial begin
        test_reset();
        load_frame();
        test_stream();
        test_pause();
        test_ignore_mid();
        test_back_to_back();
        test_reset_mid();
        test_write_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/image_streamer.md
# image_streamer

Frame source that drives the pixel-stream input of `image_buffer`, the transmitter side of the pixel/valid interface. A host preloads one ROW_SIZE×COL_SIZE frame into an internal RAM through a write port. A `start` pulse then streams the frame out in raster order as `pixel_data_out`/`data_out_valid`, with optional stall bubbles, row-end and frame-end markers. It replaces testbench-driven stimulus in system-level runs of the convolution front end.

## Interface
- DATA_SIZE, 8, pixel width in bits
- ROW_SIZE, 28, pixels per row (image width)
- COL_SIZE, 28, rows per frame (image height)
- ADDR_WIDTH, $clog2(ROW_SIZE*COL_SIZE), frame RAM address width

Ports:
- clock  in  1  single clock, all logic on rising edge
- resetn  in  1  reset, asynchronous and active-low
- wr_en  in  1  frame RAM write strobe
- wr_addr  in  ADDR_WIDTH  write address, raster index row*ROW_SIZE+col
- wr_data  in  DATA_SIZE  write pixel
- start  in  1  begin streaming one frame
- pause  in  1  stall request; suppresses the pixel for this edge
- pixel_data_out  out  DATA_SIZE  streamed pixel, connects to image_buffer pixel input
- data_out_valid  out  1  pixel qualifier, connects to image_buffer data_in_valid
- row_last  out  1  high with the last pixel of each row
- frame_done  out  1  high with the last pixel of the frame
- busy  out  1  high while in STREAM

## Operation
- FSM with two states, IDLE and STREAM.
- IDLE: `wr_en` writes `wr_data` to RAM[`wr_addr`]. Writes with `wr_addr` ≥ ROW_SIZE*COL_SIZE are dropped. If `start`=1 the FSM goes to STREAM and the read address is cleared to 0.
- STREAM: on each edge with `pause`=0, output register ← RAM[rd_addr], `data_out_valid`←1, rd_addr++. The column counter wraps at ROW_SIZE−1 and the row counter then increments.
- STREAM with `pause`=1: no read, counters hold, `data_out_valid`←0, `pixel_data_out` holds its previous value.
- The read of address ROW_SIZE*COL_SIZE−1 asserts `frame_done` and `row_last` together with its pixel, and the FSM returns to IDLE.
- `start` is ignored in STREAM. `wr_en` is ignored in STREAM, so the frame cannot be corrupted mid-stream.
- `row_last`, `frame_done` and `data_out_valid` are one-cycle registered flags. Each is 0 whenever `data_out_valid` is 0.
- RAM contents persist across frames and across reset, so a frame can be re-streamed without reloading.

## Timing
- Reset, asynchronous while `resetn`=0: FSM=IDLE, counters=0, and `pixel_data_out`, `data_out_valid`, `row_last`, `frame_done`, `busy` are all 0. RAM is not cleared.
- `start` sampled at edge E0 → `busy`=1 after E0. The first pixel (RAM[0]) is valid after E1 if `pause`=0 at E1. Start-to-first-valid latency is 2 edges.
- A frame with no pauses produces exactly ROW_SIZE*COL_SIZE consecutive valid cycles. `busy` falls after the same edge that produces the last pixel.
- The earliest restart is `start` at the edge after the last pixel. This guarantees at least one `data_out_valid`=0 cycle between frames.
- `pause` acts per edge and with no extra latency. Any pause pattern yields the same pixel sequence, only spread out in time.
- A write and a start at the same IDLE edge: the write completes and streaming begins with the new data.
- Reset asserted mid-STREAM: outputs clear immediately (asynchronously) and the partial frame is abandoned. The next `start` streams from pixel 0.

## Structure
- Shared package `image_stream_pkg` holds:
  - the state enum {IDLE, STREAM}
  - the ADDR_WIDTH derivation, so `image_buffer` users share it
- Sub-module `frame_ram`:
  - single write port, single synchronous-read port
  - depth ROW_SIZE*COL_SIZE, width DATA_SIZE
  - no reset on storage
- The FSM, counters and output flags stay in `image_streamer`.

## Test plan
- Load RAM[i]=i mod 256 for i=0..783 (28×28), pulse `start` with `pause`=0 → 784 consecutive valids with values 0,1,…,255,0,…,15. `row_last` on indices 27,55,…,783. `frame_done` only with value 15 (index 783). `busy` low the next cycle.
- Same frame, `pause`=1 on every 3rd cycle of STREAM → identical 784-value sequence, `data_out_valid` low exactly on the paused cycles, no duplicated or skipped pixels.
- Pulse `start` and `wr_en` (addr 0, data 8'hAA) again mid-frame → no restart, RAM[0] unchanged, and the next frame's first pixel is still 0.
- Assert `resetn`=0 after pixel 100 → all outputs 0 immediately. After release, `start` → stream begins at pixel 0 with the RAM contents intact.
- Assert `start` at the edge after `frame_done` → exactly one invalid cycle, then pixel 0 of the second frame.
- Connect to `image_buffer` with KERNEL_SIZE=4, ROW_SIZE=28 → the first window's out_valid and contents match the golden 4×4 window of the raster pattern.
